seq_pattern_generator: RTL and testbench

Serial bit-pattern transmitter. It is the drive-side counterpart of the lab6 serial sequence detector. It captures a parallel pattern and a length on a start request, then shifts the pattern out MSB-first, one bit per clock, on a single-bit line that feeds a detector's w input. A busy/valid/done handshake lets a test controller or top-level FSM sequence multiple bursts.

---
 rtl/seq_pattern_generator_if.sv | 39 +++
 rtl/seq_pattern_generator.sv | 108 ++++++++++
 tb/tb_seq_pattern_generator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq_pattern_generator_if.sv
// Handshake/data bundle between a burst controller and seq_pattern_generator.
// Optional macro SEQGEN_REPEAT_EN adds the repeat_burst request line.
interface seq_pattern_generator_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
);
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   length;
`ifdef SEQGEN_REPEAT_EN
  // Request to resend the captured pattern after the current last bit.
  logic               repeat_burst;
`endif
  logic               w_out;
  logic               valid;
  logic               busy;
  logic               done;
  logic [1:0]         state_out;

`ifdef SEQGEN_REPEAT_EN
  modport master (
    output start, pattern, length, repeat_burst,
    input  w_out, valid, busy, done, state_out
  );
  modport slave (
    input  start, pattern, length, repeat_burst,
    output w_out, valid, busy, done, state_out
  );
`else
  modport master (
    output start, pattern, length,
    input  w_out, valid, busy, done, state_out
  );
  modport slave (
    input  start, pattern, length,
    output w_out, valid, busy, done, state_out
  );
`endif
endinterface

// File: rtl/seq_pattern_generator.sv
// Serial bit-pattern transmitter: captures pattern/length on start, shifts the
// pattern out MSB-first one bit per clock, then pulses done for one cycle.
// Optional macro SEQGEN_REPEAT_EN enables gapless repetition of the captured burst.
module seq_pattern_generator #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input logic                  clock,
  input logic                  resetn,
  seq_pattern_generator_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] CntOne  = LEN_W'(1);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_clamped;
  logic [MAX_LEN-1:0] shifted;

`ifdef SEQGEN_REPEAT_EN
  // Copy of the start-time request, so repeats ignore the live inputs.
  logic [MAX_LEN-1:0] pat_cap_q, pat_cap_d;
  logic [LEN_W-1:0]   len_cap_q, len_cap_d;
`endif

  assign len_clamped = (bus.length > MaxLenW) ? MaxLenW : bus.length;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef SEQGEN_REPEAT_EN
      pat_cap_q <= '0;
      len_cap_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef SEQGEN_REPEAT_EN
      pat_cap_q <= pat_cap_d;
      len_cap_q <= len_cap_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SEQGEN_REPEAT_EN
    pat_cap_d = pat_cap_q;
    len_cap_d = len_cap_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          shreg_d = bus.pattern;
          cnt_d   = len_clamped;
`ifdef SEQGEN_REPEAT_EN
          pat_cap_d = bus.pattern;
          len_cap_d = len_clamped;
`endif
          state_d = (len_clamped == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
`ifdef SEQGEN_REPEAT_EN
          if (bus.repeat_burst) begin
            shreg_d = pat_cap_q;
            cnt_d   = len_cap_q;
          end else begin
            state_d = StDone;
          end
`else
          state_d = StDone;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs: current bit selected by the remaining-bit count.
  always_comb begin
    shifted       = shreg_q >> (cnt_q - CntOne);
    bus.valid     = (state_q == StShift);
    bus.w_out     = bus.valid ? shifted[0] : 1'b0;
    bus.busy      = (state_q != StIdle);
    bus.done      = (state_q == StDone);
    bus.state_out = state_q;
  end

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Bench for seq_pattern_generator: directed and random bursts compared against
// a bit-list model built from the pattern/length rules.
module tb_seq_pattern_generator;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  logic clock;
  logic resetn;
  int   tests;
  int   fails;

  seq_pattern_generator_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  seq_pattern_generator #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, {6'd0, bus.state_out}, 8'd0);
    chk({tag, "_flags"}, {4'd0, bus.w_out, bus.valid, bus.busy, bus.done}, 8'd0);
  endtask

  // Starts a burst from an IDLE cycle and checks it through the following IDLE
  // cycle; returns without ticking so a following call is back-to-back.
  task automatic do_burst(input logic [7:0] pat, input logic [3:0] len, input bit noise);
    int        l;
    logic      exp_bits[$];
    l = (len > 4'(MAX_LEN)) ? int'(MAX_LEN) : int'(len);
    exp_bits.delete();
    for (int i = 0; i < l; i++) exp_bits.push_back(pat[l-1-i]);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.length  = len;
    tick();
    for (int c = 1; c <= l + 1; c++) begin
      if (noise) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.pattern = 8'($urandom);
        bus.length  = 4'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      if (c <= l) begin
        chk($sformatf("bit%0d", c - 1), {6'd0, bus.valid, bus.w_out}, {6'd0, 1'b1, exp_bits[c-1]});
        chk($sformatf("shift%0d_busy_done", c), {6'd0, bus.busy, bus.done}, 8'h02);
      end else begin
        chk("done_cycle", {4'd0, bus.w_out, bus.valid, bus.busy, bus.done}, 8'h03);
        chk("done_state", {6'd0, bus.state_out}, 8'h02);
      end
      tick();
    end
    bus.start = 1'b0;
    chk_idle("after_burst");
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    resetn      = 1'b0;
    bus.start   = 1'b1;
    bus.pattern = 8'hFF;
    bus.length  = 4'd3;
`ifdef SEQGEN_REPEAT_EN
    bus.repeat_burst = 1'b0;
`endif
    tick();
    tick();
    chk_idle("reset");
    bus.start = 1'b0;
    resetn    = 1'b1;
    tick();
    chk_idle("idle_hold");

    do_burst(8'b0000_1101, 4'd4, 1'b0);
    tick();
    do_burst(8'h5A, 4'd0, 1'b0);
    tick();
    do_burst(8'hA5, 4'd9, 1'b0);
    tick();
    do_burst(8'h0F, 4'd4, 1'b1);
    tick();

    // Mid-burst reset abandons the transfer with no done pulse.
    bus.start   = 1'b1;
    bus.pattern = 8'hC3;
    bus.length  = 4'd8;
    tick();
    bus.start = 1'b0;
    chk("mid_rst_b0", {7'd0, bus.w_out}, 8'd1);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk_idle("mid_rst");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_idle("post_rst");
    end

    // Back-to-back bursts with start effectively held.
    do_burst(8'h96, 4'd3, 1'b0);
    do_burst(8'h01, 4'd1, 1'b0);
    do_burst(8'h6C, 4'd7, 1'b0);
    tick();

    for (int r = 0; r < 25; r++) begin
      do_burst(8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) tick();
    end

`ifdef SEQGEN_REPEAT_EN
    tick();
    bus.start        = 1'b1;
    bus.pattern      = 8'b0000_0101;
    bus.length       = 4'd3;
    bus.repeat_burst = 1'b1;
    tick();
    bus.start   = 1'b0;
    bus.pattern = 8'h00;
    for (int c = 1; c <= 9; c++) begin
      if (c == 9) bus.repeat_burst = 1'b0;
      chk($sformatf("rpt_bit%0d", c - 1), {6'd0, bus.valid, bus.w_out},
          {6'd0, 1'b1, ((c - 1) % 3 == 1) ? 1'b0 : 1'b1});
      chk("rpt_no_done", {7'd0, bus.done}, 8'd0);
      tick();
    end
    chk("rpt_done", {7'd0, bus.done}, 8'd1);
    tick();
    chk_idle("rpt_idle");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
